// File: rtl/cell_sweep_pkg.sv
// rtl/cell_sweep_pkg.sv - shared state type, vector constants and saturating add for cell_sweep_ctrl
package cell_sweep_pkg;

  localparam int NVEC = 8;
  localparam int VECW = 3;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_SAMPLE,
    S_DONE
  } sweep_state_t;

  // Add b to a, clamping at max instead of wrapping; callers truncate to their own width.
  function automatic logic [31:0] sat_add(input logic [31:0] a,
                                          input logic [31:0] b,
                                          input logic [31:0] max);
    logic [32:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return (sum > {1'b0, max}) ? max : sum[31:0];
  endfunction

endpackage

// File: rtl/cell_sweep_cmp.sv
// rtl/cell_sweep_cmp.sv - combinational per-cell mismatch vector and its popcount
import cell_sweep_pkg::*;

module cell_sweep_cmp #(
  parameter int NCELL = 4,
  parameter int PW    = 3
) (
  input  logic [NVEC*NCELL-1:0] truth,
  input  logic [NCELL-1:0]      cut_nq,
  input  logic [VECW-1:0]       vec,
  output logic [NCELL-1:0]      mm,
  output logic [PW-1:0]         pop
);

  // Each cell gets its own 8-entry truth row, indexed by the shared input vector.
  for (genvar c = 0; c < NCELL; c++) begin : g_cell
    logic [NVEC-1:0] row;
    assign row   = truth[c*NVEC +: NVEC];
    assign mm[c] = cut_nq[c] ^ row[vec];
  end

  // Number of cells that disagree with their truth table on this vector.
  always_comb begin
    pop = '0;
    for (int c = 0; c < NCELL; c++) begin
      pop = pop + PW'(mm[c]);
    end
  end

endmodule

// File: rtl/cell_sweep_ctrl.sv
// rtl/cell_sweep_ctrl.sv - sweep sequencer for 3-input cells-under-test; optional abort via CELL_SWEEP_ABORT_EN
import cell_sweep_pkg::*;

module cell_sweep_ctrl #(
  parameter int NCELL  = 4,
  parameter int SETTLE = 2,
  parameter int ERRW   = 8
) (
  input  logic                  ck,
  input  logic                  nrst,
  input  logic                  start,
`ifdef CELL_SWEEP_ABORT_EN
  input  logic                  abort,
`endif
  input  logic [NVEC*NCELL-1:0] truth,
  input  logic [NCELL-1:0]      cut_nq,
  output logic [VECW-1:0]       vec,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [NCELL-1:0]      fail_mask,
  output logic [ERRW-1:0]       err_cnt
);

  localparam int               CNTW     = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam int               PW       = $clog2(NCELL + 1);
  localparam logic [CNTW-1:0]  CNT_LAST = CNTW'(SETTLE - 1);
  localparam logic [VECW-1:0]  VEC_LAST = VECW'(NVEC - 1);
  localparam logic [ERRW-1:0]  ERR_MAX  = '1;

  sweep_state_t    state;
  logic [CNTW-1:0] cnt;
  logic [NCELL-1:0] mm;
  logic [PW-1:0]   pop;
  logic [NCELL-1:0] fm_next;
  logic [ERRW-1:0] err_next;
  logic            abort_req;

`ifdef CELL_SWEEP_ABORT_EN
  assign abort_req = abort;
`else
  assign abort_req = 1'b0;
`endif

  cell_sweep_cmp #(
    .NCELL (NCELL),
    .PW    (PW)
  ) u_cmp (
    .truth  (truth),
    .cut_nq (cut_nq),
    .vec    (vec),
    .mm     (mm),
    .pop    (pop)
  );

  assign fm_next  = fail_mask | mm;
  assign err_next = ERRW'(sat_add(32'(err_cnt), 32'(pop), 32'(ERR_MAX)));

  // Sweep FSM: settle count, vector stepping and result accumulation, all outputs registered.
  always_ff @(posedge ck or negedge nrst) begin
    if (!nrst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      vec       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      fail_mask <= '0;
      err_cnt   <= '0;
    end else begin
      done <= 1'b0;
      if (abort_req && (state == S_SETTLE || state == S_SAMPLE)) begin
        // Abort beats a same-edge sample; partial mask and count are kept for debug.
        state <= S_IDLE;
        busy  <= 1'b0;
        vec   <= '0;
        cnt   <= '0;
        pass  <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (start) begin
              state     <= S_SETTLE;
              vec       <= '0;
              cnt       <= '0;
              busy      <= 1'b1;
              pass      <= 1'b0;
              fail_mask <= '0;
              err_cnt   <= '0;
            end
          end
          S_SETTLE: begin
            if (cnt == CNT_LAST) begin
              state <= S_SAMPLE;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          S_SAMPLE: begin
            fail_mask <= fm_next;
            err_cnt   <= err_next;
            if (vec == VEC_LAST) begin
              // Results are final on this edge so pass is valid alongside done.
              state <= S_DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
              pass  <= (fm_next == '0);
            end else begin
              vec   <= vec + 1'b1;
              cnt   <= '0;
              state <= S_SETTLE;
            end
          end
          S_DONE: begin
            state <= S_IDLE;
          end
          default: begin
            state <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_cell_sweep_ctrl.sv
// tb/tb_cell_sweep_ctrl.sv - scoreboard bench for cell_sweep_ctrl with or21nand cell models
module tb_cell_sweep_ctrl;

  localparam int NCELL    = 4;
  localparam int SETTLE   = 2;
  localparam int ERRW     = 8;
  localparam int SAT_ERRW = 2;
  localparam int LAT      = 8 * (SETTLE + 1);

  typedef struct {
    logic       pass;
    logic [3:0] mask;
    int         err;
  } exp_t;

  exp_t sbq[$];
  int   tests = 0;
  int   fails = 0;

  logic                 ck   = 1'b0;
  logic                 nrst = 1'b1;
  logic                 start = 1'b0;
  logic [8*NCELL-1:0]   truth;
  logic [NCELL-1:0]     cut_nq, cut_nq_sat, stuck0;
  logic [2:0]           vec, vec_s;
  logic                 busy, done, pass, busy_s, done_s, pass_s;
  logic [NCELL-1:0]     fail_mask, fail_mask_s;
  logic [ERRW-1:0]      err_cnt;
  logic [SAT_ERRW-1:0]  err_cnt_s;
`ifdef CELL_SWEEP_ABORT_EN
  logic                 abort = 1'b0;
`endif

  always #5 ck = ~ck;

  cell_sweep_ctrl #(.NCELL(NCELL), .SETTLE(SETTLE), .ERRW(ERRW)) dut (
    .ck(ck), .nrst(nrst), .start(start),
`ifdef CELL_SWEEP_ABORT_EN
    .abort(abort),
`endif
    .truth(truth), .cut_nq(cut_nq), .vec(vec), .busy(busy), .done(done),
    .pass(pass), .fail_mask(fail_mask), .err_cnt(err_cnt)
  );

  cell_sweep_ctrl #(.NCELL(NCELL), .SETTLE(SETTLE), .ERRW(SAT_ERRW)) dut_sat (
    .ck(ck), .nrst(nrst), .start(start),
`ifdef CELL_SWEEP_ABORT_EN
    .abort(abort),
`endif
    .truth(truth), .cut_nq(cut_nq_sat), .vec(vec_s), .busy(busy_s), .done(done_s),
    .pass(pass_s), .fail_mask(fail_mask_s), .err_cnt(err_cnt_s)
  );

  function automatic logic or21nand(input logic [2:0] v);
    return ~(v[2] & (v[1] | v[0]));
  endfunction

  always_comb begin
    cut_nq     = '0;
    cut_nq_sat = '0;
    for (int c = 0; c < NCELL; c++) begin
      cut_nq[c]     = or21nand(vec) & ~stuck0[c];
      cut_nq_sat[c] = ~or21nand(vec_s);
    end
  end

  task automatic chk(input string name, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  int   nc = 0;
  int   t0 = 0;
  logic busy_d = 1'b0;

  always @(negedge ck) begin
    exp_t e;
    nc++;
    if (busy && !busy_d) t0 = nc;
    busy_d = busy;
    if (done) begin
      if (sbq.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        e = sbq.pop_front();
        chk("pass", pass, e.pass);
        chk("fail_mask", fail_mask, e.mask);
        chk("err_cnt", err_cnt, e.err);
        chk("done_latency", nc - t0, LAT);
        chk("busy_in_done", busy, 0);
        chk("sat_done", done_s, 1);
        chk("sat_err_cnt", err_cnt_s, 3);
        chk("sat_fail_mask", fail_mask_s, 4'hF);
        chk("sat_pass", pass_s, 0);
      end
    end
  end

  task automatic pulse_start();
    start = 1'b1;
    @(negedge ck);
    start = 1'b0;
  endtask

  task automatic wait_sweep();
    int n = 0;
    while (!done && n < 200) begin
      @(negedge ck);
      n++;
    end
    if (!done) chk("sweep_timeout", 0, 1);
    @(negedge ck);
  endtask

  task automatic wait_vec(input logic [2:0] v);
    int n = 0;
    while (vec != v && n < 200) begin
      @(negedge ck);
      n++;
    end
    if (vec != v) chk("wait_vec_timeout", vec, v);
  endtask

  initial begin
    exp_t e;
    truth  = {NCELL{8'h1F}};
    stuck0 = '0;
    #2 nrst = 1'b0;
    repeat (3) @(posedge ck);
    @(negedge ck);
    chk("rst_vec", vec, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_pass", pass, 0);
    chk("rst_fail_mask", fail_mask, 0);
    chk("rst_err_cnt", err_cnt, 0);
    nrst = 1'b1;
    repeat (3) @(negedge ck);
    chk("idle_busy", busy, 0);
    chk("idle_vec", vec, 0);

    // Golden sweep with vector/timing trace.
    e = '{pass: 1'b1, mask: 4'h0, err: 0};
    sbq.push_back(e);
    pulse_start();
    for (int k = 0; k < LAT; k++) begin
      chk("golden_vec", vec, k / (SETTLE + 1));
      chk("golden_busy", busy, 1);
      chk("golden_no_early_done", done, 0);
      @(negedge ck);
    end
    wait_sweep();
    chk("vec_hold_7", vec, 7);
    chk("idle_after_done", busy, 0);

    // Cell 2 stuck at 0: mismatches on v=0..4.
    stuck0 = 4'b0100;
    e = '{pass: 1'b0, mask: 4'b0100, err: 5};
    sbq.push_back(e);
    pulse_start();
    wait_sweep();

    // Start held high: sweeps accepted at edges 0 and 26 only; second restarts counts.
    sbq.push_back(e);
    sbq.push_back(e);
    start = 1'b1;
    repeat (40) @(negedge ck);
    start = 1'b0;
    wait_sweep();
    repeat (5) begin
      @(negedge ck);
      chk("held_no_third_sweep", busy, 0);
    end

    // Asynchronous reset mid-sweep at vec=3.
    stuck0 = '0;
    pulse_start();
    wait_vec(3'd3);
    nrst = 1'b0;
    #1;
    chk("arst_vec", vec, 0);
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    chk("arst_fail_mask", fail_mask, 0);
    chk("arst_err_cnt", err_cnt, 0);
    @(negedge ck);
    nrst = 1'b1;
    repeat (4) @(negedge ck);
    chk("arst_stays_idle", busy, 0);

`ifdef CELL_SWEEP_ABORT_EN
    // Abort at vec=3 with cell 2 stuck: three mismatches (v=0,1,2) retained.
    stuck0 = 4'b0100;
    pulse_start();
    wait_vec(3'd3);
    abort = 1'b1;
    @(negedge ck);
    abort = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_vec", vec, 0);
    chk("abort_pass", pass, 0);
    chk("abort_done", done, 0);
    chk("abort_err_cnt", err_cnt, 3);
    chk("abort_fail_mask", fail_mask, 4'b0100);
    repeat (30) @(negedge ck);
    chk("abort_stays_idle", busy, 0);
`endif

    repeat (3) @(negedge ck);
    chk("scoreboard_empty", sbq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/cell_sweep_ctrl.md
# cell_sweep_ctrl

Sequencer for built-in exercise of a bank of 3-input combinational cells-under-test (CUT) from the 9-track 3.3 V cell library, e.g. `or21nand_x0`. The block drives one shared 3-bit input vector to all cells and steps through all 8 input combinations. After a programmable settle time it samples each cell's `nq` and compares it against a per-cell 8-entry truth table. It reports a pass flag, a per-cell failure mask and a saturating mismatch count, and sits between the test-mode register file and the cell bank.

## Interface
- `NCELL`, 4: number of cells-under-test.
- `SETTLE`, 2: settle cycles per vector; minimum 1.
- `ERRW`, 8: width of the mismatch counter.

- `ck`  in  1  clock; all flops update on the rising edge.
- `nrst`  in  1  asynchronous, active-low reset.
- `start`  in  1  request a sweep; accepted only in IDLE.
- `truth`  in  8*NCELL  expected outputs. Bit `truth[c*8+v]` is the expected `nq` of cell c for vector v.
- `cut_nq`  in  NCELL  cell outputs; bit c is cell c.
- `vec`  out  3  shared CUT inputs `{i2,i1,i0}`.
- `busy`  out  1  high while a sweep is in progress.
- `done`  out  1  one-cycle completion pulse.
- `pass`  out  1  last completed sweep had zero mismatches.
- `fail_mask`  out  NCELL  bit c is set if cell c mismatched on any vector.
- `err_cnt`  out  ERRW  total cell-vector mismatches, saturating at 2^ERRW-1.

## Operation
- States are IDLE, SETTLE, SAMPLE and DONE.
- IDLE:
  - `start=1` → SETTLE, with `vec<=0` and `cnt<=0`.
  - `fail_mask`, `err_cnt` and `pass` clear on the same edge.
- SETTLE: `cnt` increments each edge; when `cnt==SETTLE-1` → SAMPLE.
- SAMPLE:
  - Compute `mm[c] = cut_nq[c] ^ truth[c*8+vec]`.
  - `fail_mask |= mm`.
  - `err_cnt += popcount(mm)`, saturating; there is no wrap.
  - If `vec==7` → DONE; otherwise `vec++`, `cnt<=0`, → SETTLE.
- DONE:
  - `done=1` for exactly this one cycle.
  - `pass` is registered as `fail_mask==0`.
  - Next edge → IDLE.
- `start` is ignored in SETTLE, SAMPLE and DONE; no request is queued.
- A `start` held continuously produces a new sweep only once the block is back in IDLE.
- `vec` holds its last value, 7, in IDLE after a sweep.
- `truth` must be stable while `busy=1`; it is sampled only in SAMPLE.

## Timing
- Reset values: `vec=0`, `busy=0`, `done=0`, `pass=0`, `fail_mask=0`, `err_cnt=0`, state IDLE.
- `nrst` asserted mid-sweep clears all outputs immediately; `done` is not pulsed.
- `busy`:
  - High from the edge that accepts `start` through the final SAMPLE edge.
  - Low in DONE.
- With the accepting edge numbered 0:
  - Vector v is driven from edge v·(SETTLE+1).
  - Vector v is sampled at edge (v+1)·(SETTLE+1)−… more precisely, on the SAMPLE cycle that ends at edge (v+1)·(SETTLE+1).
- `done` is high in the cycle following edge 8·(SETTLE+1); this is cycle 24 for SETTLE=2.
- `pass`, `fail_mask` and `err_cnt` are final and valid when `done=1`, and hold until the next accepted `start`.
- Every output is registered; no input reaches an output combinationally.

## Configuration
- `CELL_SWEEP_ABORT_EN` defined:
  - Adds input port `abort` (1 bit).
  - `abort=1` in SETTLE or SAMPLE → IDLE on the next edge, with `busy=0`, `vec=0` and `pass=0`.
  - No `done` pulse; `fail_mask` and `err_cnt` keep their partial values.
  - `abort` has priority over a SAMPLE update on the same edge.
  - `abort` is ignored in IDLE and DONE.
- Not defined: no `abort` port; every sweep runs to completion.

## Structure
- Package `cell_sweep_pkg` holds:
  - the state enum (IDLE/SETTLE/SAMPLE/DONE);
  - `NVEC=8` and `VECW=3`;
  - the saturating-add helper function.
- Sub-module `cell_sweep_cmp` is purely combinational. It computes the NCELL mismatch vector and its popcount from `cut_nq`, `truth` and `vec`.
- The top level holds the FSM, the settle counter, `vec` and the result registers.

## Test plan
- Reset: hold `nrst=0`, toggle `ck` → all outputs 0; release with `start=0` → stays IDLE, `busy=0`.
- Golden sweep:
  - Setup: NCELL=4, SETTLE=2, four behavioural `or21nand` models, `truth={4{8'h1F}}`, one-cycle `start`.
  - Expect `vec` stepping 0..7, each held 3 cycles, and `done` high exactly once, 24 cycles after start.
  - Expect `pass=1`, `fail_mask=0`, `err_cnt=0`.
- Stuck-at: cell 2 `nq` forced to 0 → `fail_mask=4'b0100`, `err_cnt=5`, `pass=0`.
- Saturation: ERRW=2 with all four cell outputs inverted → 32 mismatches; `err_cnt` stays at 3, `fail_mask=4'b1111`.
- Start handling:
  - `start` held high for 40 cycles → exactly one `done` per sweep; a second sweep begins only after DONE→IDLE.
  - The second sweep clears counters on its accepting edge.
- Interruption:
  - `nrst` pulsed low while `vec=3` → all outputs 0 asynchronously, no `done`.
  - With `CELL_SWEEP_ABORT_EN` defined, `abort` at `vec=3` → `busy=0` next cycle, `pass=0`, partial `err_cnt` retained.
